i2c_slave_reg_ctrl: RTL and testbench
=====================================

Name: i2c_slave_reg_ctrl

Overview:
Downstream consumer of the I2C slave bit/byte FSM.
- Interprets received bytes as slave address, register pointer and write data.
- Decides ACK/NACK per byte through the slave FSM `cmd` byte.
- Supplies the next read byte on `tx_data`, which feeds the slave FSM `din`.
- Owns a small register bank, with a registered host-side read port and a write-notify strobe.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit I2C address this slave answers to
NUM_REGS, 16, number of 8-bit registers in the bank (power of two, 2..256)
PTR_W, 4, register pointer width; must equal log2(NUM_REGS)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_  in  1  reset, synchronous, active-low
rx_data  in  8  last received byte (slave FSM `dout`)
status  in  8  slave FSM status: [3] get_start, [2] rd_done, [1] wr_done
scl_i  in  1  synchronized SCL, used for STOP detection
sda_i  in  1  synchronized SDA, used for STOP detection
tx_data  out  8  byte to transmit on master read (slave FSM `din`)
cmd  out  8  [7] ACK request, [6] NACK request, [5:0] always 0
busy  out  1  high whenever the FSM is not in IDLE
wr_strobe  out  1  one-cycle pulse when a register is written over I2C
wr_addr  out  PTR_W  register index of the last I2C write
host_addr  in  PTR_W  host read index
host_rdata  out  8  regs[host_addr], one cycle latency

Behaviour:
Reset:
- While rst_=0 at a clk edge, state is IDLE and ptr=0.
- All registers are 0; tx_data=0, cmd=0, busy=0, wr_strobe=0, wr_addr=0, host_rdata=0.
- Reset mid-transaction aborts it. No partial write survives.

Event decode (registered previous values, all 1-cycle pulses):
- start = rising edge of status[3]
- byte_rx = rising edge of status[2]
- byte_tx = rising edge of status[1]
- stop = scl_i & sda_i & ~sda_prev

Event priority in one cycle: reset > stop > start > byte_rx/byte_tx.

States: IDLE, ADDR, PTR, WDATA, RDATA, IGNORE.

Transitions:
- Any state, on stop: go to IDLE; cmd=0; ptr is retained.
- Any state, on start: go to ADDR; cmd=0. Repeated start keeps ptr.
- ADDR, on byte_rx:
  - If rx_data[7:1]==SLAVE_ADDR: cmd=8'h80 (ACK).
    - rx_data[0]=1: go to RDATA; tx_data=regs[ptr].
    - Otherwise: go to PTR.
  - Mismatch: cmd=8'h40 (NACK); go to IGNORE.
- PTR, on byte_rx:
  - If rx_data < NUM_REGS: ptr=rx_data[PTR_W-1:0]; cmd=8'h80; go to WDATA.
  - Otherwise: cmd=8'h40; go to IGNORE; ptr unchanged.
- WDATA, on byte_rx:
  - regs[ptr]=rx_data; wr_addr=ptr; wr_strobe=1 for one cycle.
  - ptr=ptr+1 modulo NUM_REGS; cmd=8'h80.
- RDATA, on byte_tx: ptr=ptr+1 modulo NUM_REGS; tx_data=regs[new ptr] on the next cycle.
- IGNORE: byte_rx and byte_tx are ignored; no register writes. Exit only via start or stop.

Timing and output rules:
- cmd updates on the clk edge after byte_rx; it is held until the next byte_rx, start or stop.
- Upstream samples cmd at the following SCL falling edge, so 1-cycle latency is sufficient.
- Pointer wrap: 0x0F+1 gives 0x00 with default parameters.
- busy = (state != IDLE), registered.
- host_rdata <= regs[host_addr] every cycle.
- Host read of the register being written in the same cycle returns the old value.

Decomposition:
- Package i2c_pkg holds:
  - state encoding constants IDLE..IGNORE
  - CMD_ACK=8'h80 and CMD_NACK=8'h40
  - STATUS bit indices (ST_GET_START=3, ST_RD_DONE=2, ST_WR_DONE=1)
- One sub-module, i2c_slave_regbank:
  - NUM_REGS x 8 array
  - write port (we, waddr, wdata)
  - combinational read for tx_data
  - registered host read port
  - synchronous active-low clear

Test Plan:
- Write: start, 0xA0, 0x03, 0x5A, 0xC3, stop -> cmd=0x80 after each byte; regs[3]=0x5A, regs[4]=0xC3; wr_strobe pulses twice with wr_addr 3 then 4; busy=0 after stop.
- Read via repeated start: start, 0xA0, 0x03, start, 0xA1 -> ACK, tx_data=0x5A; byte_tx -> tx_data=0xC3; byte_tx -> tx_data=regs[5]=0x00.
- Address mismatch: start, 0xA2, 0x01, 0xFF -> cmd=0x40 after first byte; state IGNORE; no wr_strobe; regs unchanged.
- Pointer wrap and range: pointer 0x0F then data 0x11, 0x22 -> regs[15]=0x11, regs[0]=0x22. Pointer 0x10 -> NACK, ptr unchanged.
- Priority: start and byte_rx in the same cycle -> state ADDR, cmd=0, no write. Stop in WDATA -> IDLE, cmd=0.
- Reset mid-write after the pointer byte: rst_=0 for one clk -> all outputs 0, regs all 0, state IDLE, host_rdata=0 on the next read.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C slave register controller: FSM states, ACK/NACK command
// bytes and the bit positions of the slave FSM status word.
package i2c_pkg;

  localparam int unsigned REG_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    PTR,
    WDATA,
    RDATA,
    IGNORE
  } state_t;

  localparam logic [7:0] CMD_ACK  = 8'h80;
  localparam logic [7:0] CMD_NACK = 8'h40;

  localparam int unsigned ST_GET_START = 3;
  localparam int unsigned ST_RD_DONE   = 2;
  localparam int unsigned ST_WR_DONE   = 1;

endpackage

// File: rtl/i2c_slave_regbank.sv
// Register bank behind the I2C slave: one write port, a combinational read for the transmit
// path and a registered host read port.
module i2c_slave_regbank
  import i2c_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned PTR_W    = 4
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [REG_W-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [REG_W-1:0] rdata,
  input  logic [PTR_W-1:0] host_addr,
  output logic [REG_W-1:0] host_rdata
);

  logic [REG_W-1:0] regs [NUM_REGS];

  assign rdata = regs[raddr];

  // Host port samples before the write lands, so a same-cycle write returns the old value.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      host_rdata <= '0;
    end else begin
      if (we) begin
        regs[waddr] <= wdata;
      end
      host_rdata <= regs[host_addr];
    end
  end

endmodule

// File: rtl/i2c_slave_reg_ctrl.sv
// Byte-level protocol layer on top of the I2C slave FSM: decodes address, pointer and data
// bytes, answers ACK/NACK via cmd and serves read data from the register bank.
module i2c_slave_reg_ctrl
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned PTR_W      = 4
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [7:0]       rx_data,
  input  logic [7:0]       status,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic [7:0]       tx_data,
  output logic [7:0]       cmd,
  output logic             busy,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_addr,
  input  logic [PTR_W-1:0] host_addr,
  output logic [7:0]       host_rdata
);

  state_t           state;
  logic [PTR_W-1:0] ptr, ptr_inc, rd_addr;
  logic [REG_W-1:0] rd_data;
  logic             start_q, rd_done_q, wr_done_q, sda_q;
  logic             start, byte_rx, byte_tx, stop, we, ptr_ok;
  logic             unused_status;

  assign start   = status[ST_GET_START] & ~start_q;
  assign byte_rx = status[ST_RD_DONE] & ~rd_done_q;
  assign byte_tx = status[ST_WR_DONE] & ~wr_done_q;
  assign stop    = scl_i & sda_i & ~sda_q;

  // Writes only happen when no higher-priority bus event shares the cycle.
  assign we      = (state == WDATA) & byte_rx & ~stop & ~start;
  assign ptr_inc = ptr + PTR_W'(1);
  assign rd_addr = (state == RDATA) ? ptr_inc : ptr;
  assign ptr_ok  = (rx_data >> PTR_W) == '0;

  assign unused_status = ^{status[7:4], status[0]};

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state     <= IDLE;
      ptr       <= '0;
      cmd       <= '0;
      tx_data   <= '0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      start_q   <= 1'b0;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
      sda_q     <= 1'b0;
    end else begin
      start_q   <= status[ST_GET_START];
      rd_done_q <= status[ST_RD_DONE];
      wr_done_q <= status[ST_WR_DONE];
      sda_q     <= sda_i;
      wr_strobe <= 1'b0;
      if (stop) begin
        state <= IDLE;
        cmd   <= '0;
        busy  <= 1'b0;
      end else if (start) begin
        state <= ADDR;
        cmd   <= '0;
        busy  <= 1'b1;
      end else begin
        case (state)
          ADDR: begin
            if (byte_rx) begin
              if (rx_data[7:1] == SLAVE_ADDR) begin
                cmd <= CMD_ACK;
                if (rx_data[0]) begin
                  state   <= RDATA;
                  tx_data <= rd_data;
                end else begin
                  state <= PTR;
                end
              end else begin
                cmd   <= CMD_NACK;
                state <= IGNORE;
              end
            end
          end
          PTR: begin
            if (byte_rx) begin
              if (ptr_ok) begin
                ptr   <= rx_data[PTR_W-1:0];
                cmd   <= CMD_ACK;
                state <= WDATA;
              end else begin
                cmd   <= CMD_NACK;
                state <= IGNORE;
              end
            end
          end
          WDATA: begin
            if (byte_rx) begin
              wr_addr   <= ptr;
              wr_strobe <= 1'b1;
              ptr       <= ptr_inc;
              cmd       <= CMD_ACK;
            end
          end
          RDATA: begin
            if (byte_tx) begin
              ptr     <= ptr_inc;
              tx_data <= rd_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

  i2c_slave_regbank #(
    .NUM_REGS (NUM_REGS),
    .PTR_W    (PTR_W)
  ) u_regbank (
    .clk        (clk),
    .rst_       (rst_),
    .we         (we),
    .waddr      (ptr),
    .wdata      (rx_data),
    .raddr      (rd_addr),
    .rdata      (rd_data),
    .host_addr  (host_addr),
    .host_rdata (host_rdata)
  );

endmodule

// File: tb/tb_i2c_slave_reg_ctrl.sv
// Directed bench for i2c_slave_reg_ctrl: drives slave FSM status pulses and STOP conditions,
// checks cmd/tx_data/strobe behaviour and register contents through the host port.
module tb_i2c_slave_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst_;
  logic [7:0] rx_data;
  logic [7:0] status;
  logic       scl_i, sda_i;
  logic [7:0] tx_data, cmd, host_rdata;
  logic       busy, wr_strobe;
  logic [3:0] wr_addr, host_addr;

  int checks = 0;
  int errors = 0;
  int strobes = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_strobe === 1'b1) strobes++;

  i2c_slave_reg_ctrl dut (
    .clk        (clk),
    .rst_       (rst_),
    .rx_data    (rx_data),
    .status     (status),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .tx_data    (tx_data),
    .cmd        (cmd),
    .busy       (busy),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .host_addr  (host_addr),
    .host_rdata (host_rdata)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [7:0] mask, input logic [7:0] data);
    @(negedge clk);
    rx_data = data;
    status  = mask;
    @(negedge clk);
    status  = 8'h00;
  endtask

  task automatic do_start();
    pulse(8'h08, rx_data);
  endtask

  task automatic send(input logic [7:0] b);
    pulse(8'h04, b);
  endtask

  task automatic byte_done_tx();
    pulse(8'h02, rx_data);
  endtask

  task automatic do_stop();
    @(negedge clk);
    sda_i = 1'b0;
    @(negedge clk);
    sda_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic host_rd(input logic [3:0] a, input logic [7:0] exp, input string tag);
    @(negedge clk);
    host_addr = a;
    @(negedge clk);
    chk(tag, host_rdata, exp);
  endtask

  initial begin
    rst_      = 1'b0;
    rx_data   = 8'h00;
    status    = 8'h00;
    scl_i     = 1'b1;
    sda_i     = 1'b1;
    host_addr = 4'h0;
    repeat (3) @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
    chk("rst_tx", tx_data, 8'h00);
    chk("rst_cmd", cmd, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_strobe", {7'd0, wr_strobe}, 8'h00);
    chk("rst_waddr", {4'd0, wr_addr}, 8'h00);
    chk("rst_hrd", host_rdata, 8'h00);

    // Write 5A, C3 starting at register 3
    do_start();
    chk("wr_busy", {7'd0, busy}, 8'h01);
    chk("wr_start_cmd", cmd, 8'h00);
    send(8'hA0);
    chk("wr_addr_ack", cmd, 8'h80);
    send(8'h03);
    chk("wr_ptr_ack", cmd, 8'h80);
    host_addr = 4'h3;
    send(8'h5A);
    chk("wr_d0_ack", cmd, 8'h80);
    chk("wr_d0_strobe", {7'd0, wr_strobe}, 8'h01);
    chk("wr_d0_waddr", {4'd0, wr_addr}, 8'h03);
    chk("hrd_same_cycle_old", host_rdata, 8'h00);
    send(8'hC3);
    chk("wr_d1_ack", cmd, 8'h80);
    chk("wr_d1_waddr", {4'd0, wr_addr}, 8'h04);
    do_stop();
    chk("wr_stop_busy", {7'd0, busy}, 8'h00);
    chk("wr_stop_cmd", cmd, 8'h00);
    chk("wr_strobe_cnt", 8'(strobes), 8'd2);
    host_rd(4'h3, 8'h5A, "reg3");
    host_rd(4'h4, 8'hC3, "reg4");

    // Read back via repeated start
    do_start();
    send(8'hA0);
    send(8'h03);
    do_start();
    chk("rs_cmd_clr", cmd, 8'h00);
    send(8'hA1);
    chk("rd_ack", cmd, 8'h80);
    chk("rd_tx0", tx_data, 8'h5A);
    byte_done_tx();
    chk("rd_tx1", tx_data, 8'hC3);
    byte_done_tx();
    chk("rd_tx2", tx_data, 8'h00);
    do_stop();

    // Address mismatch: everything after is ignored
    do_start();
    send(8'hA2);
    chk("mm_nack", cmd, 8'h40);
    send(8'h01);
    send(8'hFF);
    chk("mm_cmd_held", cmd, 8'h40);
    chk("mm_busy", {7'd0, busy}, 8'h01);
    do_stop();
    chk("mm_no_strobe", 8'(strobes), 8'd2);
    host_rd(4'h1, 8'h00, "mm_reg1");
    host_rd(4'h3, 8'h5A, "mm_reg3");

    // Pointer wrap from 0x0F to 0x00
    do_start();
    send(8'hA0);
    send(8'h0F);
    send(8'h11);
    send(8'h22);
    chk("wrap_waddr", {4'd0, wr_addr}, 8'h00);
    do_stop();
    host_rd(4'hF, 8'h11, "wrap_reg15");
    host_rd(4'h0, 8'h22, "wrap_reg0");

    // Out-of-range pointer NACKs and leaves ptr at 0x0F
    do_start();
    send(8'hA0);
    send(8'h0F);
    do_stop();
    do_start();
    send(8'hA0);
    send(8'h10);
    chk("ptr_oor_nack", cmd, 8'h40);
    send(8'h77);
    do_stop();
    chk("ptr_oor_no_strobe", 8'(strobes), 8'd4);
    do_start();
    send(8'hA1);
    chk("ptr_kept_tx", tx_data, 8'h11);
    do_stop();

    // Start and byte_rx together: start wins, no write
    do_start();
    send(8'hA0);
    send(8'h02);
    pulse(8'h0C, 8'h99);
    chk("prio_cmd", cmd, 8'h00);
    send(8'hA0);
    chk("prio_in_addr", cmd, 8'h80);
    send(8'h02);
    do_stop();
    chk("prio_stop_cmd", cmd, 8'h00);
    chk("prio_stop_busy", {7'd0, busy}, 8'h00);
    chk("prio_no_strobe", 8'(strobes), 8'd4);
    host_rd(4'h2, 8'h00, "prio_reg2");

    // Reset after the pointer byte
    do_start();
    send(8'hA0);
    send(8'h06);
    @(negedge clk);
    rst_ = 1'b0;
    @(negedge clk);
    rst_ = 1'b1;
    chk("mr_cmd", cmd, 8'h00);
    chk("mr_busy", {7'd0, busy}, 8'h00);
    chk("mr_tx", tx_data, 8'h00);
    chk("mr_waddr", {4'd0, wr_addr}, 8'h00);
    send(8'h55);
    chk("mr_idle_no_ack", cmd, 8'h00);
    host_rd(4'h3, 8'h00, "mr_reg3");
    host_rd(4'hF, 8'h00, "mr_reg15");
    host_rd(4'h6, 8'h00, "mr_reg6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
